uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 16x-oversampled UART receiver for the 125 MHz fabric; the robust receive end of the serial link driven by the team's UART transmitter.
- Serial input is synchronized and each bit is sampled at mid-bit.
- Start-glitch rejection and framing/overrun detection are included.
- Bytes are presented on a valid/ack handshake to the downstream consumer (command parser, loopback logic).

Parameters:
- CLK_HZ, 125000000, fabric clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_TICK, (CLK_HZ+BAUD*8)/(BAUD*16) (=68), clock cycles per oversample tick; localparam, derived.

Ports:
- clk_125MHz  input  1  fabric clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_d  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until acknowledged.
- rx_ack  input  1  consumer accepts rx_d; effective only when rx_valid=1.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  output  1  sticky; set when a byte completes while rx_valid=1; cleared by rx_ack.

Behaviour:
- Reset (async, rst_n=0):
  - rx_d=0, rx_valid=0, rx_frame_err=0, rx_overrun=0.
  - Synchronizer flops=1, prescaler=0, state=IDLE.
- Synchronizer: 2-FF chain on rx; all decisions use the second-stage output rxs.
- Prescaler:
  - Free-running counter 0..CLKS_PER_TICK-1.
  - tick=1 for one cycle when counter == CLKS_PER_TICK-1; counter then wraps to 0.
  - FSM advances only on tick.
- Oversample counter os_cnt: 4 bits, 0..15. Bit counter bit_cnt: 3 bits. Shift register sh: 8 bits.
- FSM states:
  - IDLE: on tick with rxs=0 → START, os_cnt=0.
  - START:
    - os_cnt increments per tick.
    - At os_cnt==7 (mid start bit): if rxs=1 → IDLE (glitch rejected, no outputs); else os_cnt=0, bit_cnt=0 → DATA.
  - DATA:
    - At os_cnt==15 (16 ticks after previous sample): sh={rxs, sh[7:1]} (LSB first), os_cnt=0.
    - bit_cnt increments; after the 8th sample (bit_cnt==7) → STOP.
  - STOP: at os_cnt==15, sample rxs.
    - rxs=1: rx_d<=sh; if rx_valid already 1, rx_overrun<=1 and rx_d is overwritten with the new byte; rx_valid<=1 → IDLE.
    - rxs=0: rx_frame_err pulses one clk_125MHz cycle; byte discarded, rx_d/rx_valid unchanged → BREAK.
  - BREAK: stay until tick with rxs=1 → IDLE. A held-low line (break) yields exactly one frame_err.
- Handshake:
  - rx_ack while rx_valid=1: rx_valid<=0, rx_overrun<=0 next cycle.
  - rx_ack while rx_valid=0: ignored.
  - Simultaneous rx_ack and byte completion in the same cycle: new byte wins. rx_valid stays 1, rx_d updates, no overrun.
- Timing:
  - Byte completion is at mid stop bit (~9.5 bit times after the falling edge), plus 2-3 clk synchronizer latency and ≤1 tick start-detect jitter.
  - Back-to-back frames with no idle gap are received without loss.
- Tolerance: combined baud error up to ±3% is received correctly.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at os_cnt==15.
  - Expected even parity: XOR of 8 data bits and the parity bit == 0.
  - Adds output rx_parity_err (1 bit), reset 0. It is set alongside rx_valid when a byte with bad parity completes; the byte is still delivered. It is cleared with rx_valid on rx_ack.
- Undefined: no PARITY state, no rx_parity_err port; frame is 8N1.

Decomposition:
- Shared package uart_pkg: the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK), OVERSAMPLE=16, and default CLK_HZ/BAUD constants shared with the transmitter.
- One sub-module is natural: uart_baud_tick (prescaler producing the tick pulse, parameter CLKS_PER_TICK). It is reusable by a future oversampled TX.

Test Plan:
- Reset: drive rst_n=0 mid-frame (during DATA) then release → all outputs 0, FSM IDLE. The next clean frame 0xA5 is received correctly.
- Single byte: send 0x55 8N1 at 115200 → rx_valid=1, rx_d=0x55 ~9.5 bit times after the start edge, no errors. Then rx_ack → rx_valid=0.
- Glitch: drive rx low for 4 ticks (272 clk) then high → no rx_valid, no rx_frame_err, FSM back to IDLE.
- Framing: send 0x3C with stop bit 0, then hold the line low for 2 bit times → exactly one rx_frame_err pulse, rx_valid stays 0. After the line returns high, 0x81 is received normally.
- Overrun / back-to-back: send 0x12 and 0x34 with no idle gap and no rx_ack → rx_d=0x34, rx_valid=1, rx_overrun=1. Then rx_ack → both cleared.
- Baud skew: send 0xC3 at 115200×1.03 and ×0.97 → correct data both times. With UART_RX_PARITY_EN, a bad parity bit on 0x07 → rx_d=0x07, rx_parity_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio and default link settings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE     = 16;
  localparam int CLK_HZ_DEFAULT = 125000000;
  localparam int BAUD_DEFAULT   = 115200;

  // Rounded clock cycles per oversample tick.
  function automatic int clks_per_tick(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running prescaler emitting a one-cycle tick every CLKS_PER_TICK clocks.
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 68
) (
  input  logic clk_125MHz,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_125MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with start-glitch rejection, framing and overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose rx_parity_err.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BAUD   = BAUD_DEFAULT
) (
  input  logic       clk_125MHz,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_d,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_overrun
);

  localparam int CLKS_PER_TICK = clks_per_tick(CLK_HZ, BAUD);

  logic      rx_s1;
  logic      rxs;
  logic      tick;
  rx_state_t state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
`ifdef UART_RX_PARITY_EN
  logic       par_bad;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_125MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  uart_baud_tick #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick (
    .clk_125MHz(clk_125MHz),
    .rst_n     (rst_n),
    .tick      (tick)
  );

  always_ff @(posedge clk_125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      sh           <= '0;
      rx_d         <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
        rx_parity_err <= 1'b0;
`endif
      end
      // A completing byte below overrides the ack clear: the new byte wins.
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state  <= START;
              os_cnt <= '0;
            end
          end
          START: begin
            if (os_cnt == 4'd7) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                state   <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          DATA: begin
            if (os_cnt == 4'd15) begin
              os_cnt  <= '0;
              sh      <= {rxs, sh[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (os_cnt == 4'd15) begin
              os_cnt  <= '0;
              par_bad <= ^{sh, rxs};
              state   <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
`endif
          STOP: begin
            if (os_cnt == 4'd15) begin
              os_cnt <= '0;
              if (rxs) begin
                rx_d     <= sh;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                  rx_overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                rx_parity_err <= par_bad;
`endif
                state <= IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= BREAK;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          // Wait for the line to return high so a held break reports only once.
          BREAK: begin
            if (rxs) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os, run at a faster line rate to keep frames short.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CLK_HZ   = 125000000;
  localparam int BAUD     = 460800;
  localparam int CPT      = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int BIT_CLKS = 16 * CPT;

  logic       clk_125MHz = 1'b0;
  logic       rst_n      = 1'b0;
  logic       rx         = 1'b1;
  logic       rx_ack     = 1'b0;
  logic [7:0] rx_d;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int n_cmp   = 0;
  int n_bad   = 0;
  int fe_cnt  = 0;
  int fe_base = 0;

  uart_rx_os #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk_125MHz  (clk_125MHz),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_d        (rx_d),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_frame_err(rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun  (rx_overrun)
  );

  always #4 clk_125MHz = ~clk_125MHz;

  always @(posedge clk_125MHz) begin
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_125MHz);
    #1;
  endtask

  task automatic send_bit(input logic b, input int bc);
    rx = b;
    clks(bc);
  endtask

  task automatic send_head(input logic [7:0] b, input int bc);
    send_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(b[i], bc);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_bit);
    send_head(b, bc);
`ifdef UART_RX_PARITY_EN
    send_bit(^b, bc);
`endif
    send_bit(stop_bit, bc);
  endtask

  task automatic do_ack();
    @(posedge clk_125MHz);
    #1 rx_ack = 1'b1;
    @(posedge clk_125MHz);
    #1 rx_ack = 1'b0;
    @(negedge clk_125MHz);
  endtask

  initial begin
    // Reset values
    clks(5);
    @(negedge clk_125MHz);
    chk("rst_d", 32'(rx_d), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_fe", 32'(rx_frame_err), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    clks(1);
    rst_n = 1'b1;
    clks(2 * BIT_CLKS);

    // Reset asserted mid-frame
    send_bit(1'b0, BIT_CLKS);
    send_bit(1'b1, BIT_CLKS);
    send_bit(1'b0, BIT_CLKS);
    @(negedge clk_125MHz);
    chk("mid_state_data", 32'(dut.state), 32'(DATA));
    rst_n = 1'b0;
    clks(3);
    @(negedge clk_125MHz);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    clks(5);
    rst_n = 1'b1;
    clks(2 * BIT_CLKS);
    send_frame(8'hA5, BIT_CLKS, 1'b1);
    @(negedge clk_125MHz);
    chk("a5_d", 32'(rx_d), 32'hA5);
    chk("a5_valid", 32'(rx_valid), 32'd1);
`ifdef UART_RX_PARITY_EN
    chk("a5_par", 32'(rx_parity_err), 32'd0);
`endif
    do_ack();
    chk("a5_ack_valid", 32'(rx_valid), 32'd0);
    clks(BIT_CLKS);

    // Single byte with completion timing around mid stop bit
    fe_base = fe_cnt;
    send_head(8'h55, BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0, BIT_CLKS);
`endif
    rx = 1'b1;
    clks(8 * CPT - 40);
    @(negedge clk_125MHz);
    chk("55_early_valid", 32'(rx_valid), 32'd0);
    clks(CPT + 80);
    @(negedge clk_125MHz);
    chk("55_valid", 32'(rx_valid), 32'd1);
    chk("55_d", 32'(rx_d), 32'h55);
    chk("55_ovr", 32'(rx_overrun), 32'd0);
    chk("55_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
    clks(BIT_CLKS - 9 * CPT - 40);
    do_ack();
    chk("55_ack_valid", 32'(rx_valid), 32'd0);
    clks(BIT_CLKS);

    // Short start glitch of four ticks
    fe_base = fe_cnt;
    rx = 1'b0;
    clks(4 * CPT);
    rx = 1'b1;
    clks(2 * BIT_CLKS);
    @(negedge clk_125MHz);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));

    // Framing error followed by a held break, then recovery
    fe_base = fe_cnt;
    send_frame(8'h3C, BIT_CLKS, 1'b0);
    clks(2 * BIT_CLKS);
    rx = 1'b1;
    clks(2 * BIT_CLKS);
    @(negedge clk_125MHz);
    chk("frame_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);
    chk("frame_valid", 32'(rx_valid), 32'd0);
    chk("frame_fe_low", 32'(rx_frame_err), 32'd0);
    send_frame(8'h81, BIT_CLKS, 1'b1);
    @(negedge clk_125MHz);
    chk("81_d", 32'(rx_d), 32'h81);
    chk("81_valid", 32'(rx_valid), 32'd1);
    do_ack();
    clks(BIT_CLKS);

    // Back-to-back frames without ack
    send_frame(8'h12, BIT_CLKS, 1'b1);
    @(negedge clk_125MHz);
    chk("12_d", 32'(rx_d), 32'h12);
    chk("12_ovr", 32'(rx_overrun), 32'd0);
    send_frame(8'h34, BIT_CLKS, 1'b1);
    @(negedge clk_125MHz);
    chk("34_d", 32'(rx_d), 32'h34);
    chk("34_valid", 32'(rx_valid), 32'd1);
    chk("34_ovr", 32'(rx_overrun), 32'd1);
    do_ack();
    chk("34_ack_valid", 32'(rx_valid), 32'd0);
    chk("34_ack_ovr", 32'(rx_overrun), 32'd0);
    clks(BIT_CLKS);

    // Baud skew: sender 3% slow, then 3% fast
    fe_base = fe_cnt;
    send_frame(8'hC3, (BIT_CLKS * 103) / 100, 1'b1);
    @(negedge clk_125MHz);
    chk("c3_slow_d", 32'(rx_d), 32'hC3);
    chk("c3_slow_valid", 32'(rx_valid), 32'd1);
    do_ack();
    clks(BIT_CLKS);
    send_frame(8'hC3, (BIT_CLKS * 97) / 100, 1'b1);
    @(negedge clk_125MHz);
    chk("c3_fast_d", 32'(rx_d), 32'hC3);
    chk("c3_fast_valid", 32'(rx_valid), 32'd1);
    chk("c3_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
    chk("c3_ovr", 32'(rx_overrun), 32'd0);
    do_ack();
    clks(BIT_CLKS);

`ifdef UART_RX_PARITY_EN
    // Bad parity still delivers the byte
    send_head(8'h07, BIT_CLKS);
    send_bit(~(^8'h07), BIT_CLKS);
    send_bit(1'b1, BIT_CLKS);
    @(negedge clk_125MHz);
    chk("07_d", 32'(rx_d), 32'h07);
    chk("07_par", 32'(rx_parity_err), 32'd1);
    do_ack();
    chk("07_ack_par", 32'(rx_parity_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
